// File: rtl/k_aud_cmprs_pkg.sv
// Shared frame geometry and FSM encoding for the compressor energy path.
// The controller and the band accumulator both import this package.
package k_aud_cmprs_pkg;

    localparam int K_FFT_NUM_PTS = 16;
    localparam int K_NUM_BANDS   = 4;
    localparam int BINS_PER_BAND = K_FFT_NUM_PTS / K_NUM_BANDS;

    // res_cnt must be able to hold the full count, hence the +1.
    localparam int BIN_CNT_W  = $clog2(K_FFT_NUM_PTS);
    localparam int RES_CNT_W  = $clog2(K_FFT_NUM_PTS + 1);
    localparam int BAND_IDX_W = $clog2(K_NUM_BANDS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        EMIT  = 2'd3
    } state_e;

endpackage

// File: rtl/k_band_accumulator.sv
// Bank of per-band energy accumulators: clear, add-on-valid at an index,
// and an asynchronous read port selected by band index.
module k_band_accumulator
    import k_aud_cmprs_pkg::*;
#(
    parameter int IN_W  = 40,
    parameter int ACC_W = 42
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clr_i,
    input  logic                  add_i,
    input  logic [BAND_IDX_W-1:0] add_idx_i,
    input  logic [IN_W-1:0]       add_val_i,
    input  logic [BAND_IDX_W-1:0] rd_idx_i,
    output logic [ACC_W-1:0]      rd_data_o
);

    logic [ACC_W-1:0] acc_q [K_NUM_BANDS];

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values; the bank is reset because band totals are
    // observable outputs and must read as zero straight after reset.
    always_ff @(posedge clk) begin
        if (!resetn || clr_i) begin
            for (int b = 0; b < K_NUM_BANDS; b++) begin
                acc_q[b] <= '0;
            end
        end else if (add_i) begin
            acc_q[add_idx_i] <= acc_q[add_idx_i] + ACC_W'(add_val_i);
        end
    end

    assign rd_data_o = acc_q[rd_idx_i];

endmodule

// File: rtl/k_energy_frame_ctrl.sv
// Frame controller: gates one FFT frame into the energy computer, bins the
// returned energies into bands and streams the band totals downstream.
module k_energy_frame_ctrl
    import k_aud_cmprs_pkg::*;
#(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 40,
    parameter int ACC_WIDTH = OUT_WIDTH + $clog2(BINS_PER_BAND)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    enable,
    input  logic [2*IN_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_tready,
    output logic [2*IN_WIDTH-1:0]   eng_tdata,
    output logic                    eng_tvalid,
    input  logic                    eng_tready,
    input  logic [OUT_WIDTH-1:0]    eng_energy,
    input  logic                    eng_valid,
    output logic [ACC_WIDTH-1:0]    m_axis_tdata,
    output logic [BAND_IDX_W-1:0]   m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    frame_done,
    output logic                    err_tlast
);

    state_e                state_q, state_d;
    logic [BIN_CNT_W-1:0]  bin_cnt_q, bin_cnt_d;
    logic [RES_CNT_W-1:0]  res_cnt_q, res_cnt_d;
    logic [BAND_IDX_W-1:0] band_idx_q, band_idx_d;
    logic                  err_tlast_q, err_tlast_d;
    logic                  frame_done_q, frame_done_d;
    logic                  acc_clr;
    logic [ACC_WIDTH-1:0]  band_total;

    logic in_feed, in_emit, beat_acc, last_bin, capture, res_done, last_band;

    assign in_feed   = (state_q == FEED);
    assign in_emit   = (state_q == EMIT);
    assign beat_acc  = in_feed && s_axis_tvalid && eng_tready;
    assign last_bin  = (bin_cnt_q == BIN_CNT_W'(K_FFT_NUM_PTS - 1));
    assign capture   = eng_valid && (state_q == FEED || state_q == DRAIN);
    assign res_done  = capture && (res_cnt_q == RES_CNT_W'(K_FFT_NUM_PTS - 1));
    assign last_band = (band_idx_q == BAND_IDX_W'(K_NUM_BANDS - 1));

    // NOTE: every always_comb target gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        bin_cnt_d    = bin_cnt_q;
        res_cnt_d    = capture ? res_cnt_q + RES_CNT_W'(1) : res_cnt_q;
        band_idx_d   = band_idx_q;
        err_tlast_d  = beat_acc && (s_axis_tlast != last_bin);
        frame_done_d = 1'b0;
        acc_clr      = 1'b0;

        case (state_q)
            IDLE: begin
                bin_cnt_d  = '0;
                res_cnt_d  = '0;
                band_idx_d = '0;
                acc_clr    = 1'b1;
                if (enable) state_d = FEED;
            end
            FEED: begin
                if (beat_acc) begin
                    bin_cnt_d = bin_cnt_q + BIN_CNT_W'(1);
                    // A zero-latency energy source can finish in this same cycle.
                    if (last_bin) state_d = res_done ? EMIT : DRAIN;
                end
            end
            DRAIN: begin
                if (res_done) state_d = EMIT;
            end
            EMIT: begin
                if (m_axis_tready) begin
                    band_idx_d = band_idx_q + BAND_IDX_W'(1);
                    if (last_band) begin
                        state_d      = IDLE;
                        frame_done_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            bin_cnt_q    <= '0;
            res_cnt_q    <= '0;
            band_idx_q   <= '0;
            err_tlast_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bin_cnt_q    <= bin_cnt_d;
            res_cnt_q    <= res_cnt_d;
            band_idx_q   <= band_idx_d;
            err_tlast_q  <= err_tlast_d;
            frame_done_q <= frame_done_d;
        end
    end

    k_band_accumulator #(
        .IN_W  (OUT_WIDTH),
        .ACC_W (ACC_WIDTH)
    ) u_band_acc (
        .clk       (clk),
        .resetn    (resetn),
        .clr_i     (acc_clr),
        .add_i     (capture),
        .add_idx_i (BAND_IDX_W'(res_cnt_q >> $clog2(BINS_PER_BAND))),
        .add_val_i (eng_energy),
        .rd_idx_i  (band_idx_q),
        .rd_data_o (band_total)
    );

    assign s_axis_tready = in_feed && eng_tready;
    assign eng_tvalid    = in_feed && s_axis_tvalid;
    assign eng_tdata     = in_feed ? s_axis_tdata : '0;

    // Band outputs come straight from registers and only change on handshake.
    assign m_axis_tvalid = in_emit;
    assign m_axis_tdata  = in_emit ? band_total : '0;
    assign m_axis_tuser  = in_emit ? band_idx_q : '0;
    assign m_axis_tlast  = in_emit && last_band;
    assign frame_done    = frame_done_q;
    assign err_tlast     = err_tlast_q;

endmodule

// File: tb/tb_k_energy_frame_ctrl.sv
// Directed bench for k_energy_frame_ctrl with a latency-3 re^2+im^2 model
// standing in for the energy computer.
module tb_k_energy_frame_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic [31:0] eng_tdata;
    logic        eng_tvalid;
    logic        eng_tready;
    logic [39:0] eng_energy;
    logic        eng_valid;
    logic [41:0] m_axis_tdata;
    logic [1:0]  m_axis_tuser;
    logic        m_axis_tlast;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        frame_done;
    logic        err_tlast;

    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;
    int err_cnt  = 0;
    logic tog     = 1'b0;
    logic chk_rdy = 1'b0;

    always #5 clk = ~clk;

    k_energy_frame_ctrl dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .eng_tdata     (eng_tdata),
        .eng_tvalid    (eng_tvalid),
        .eng_tready    (eng_tready),
        .eng_energy    (eng_energy),
        .eng_valid     (eng_valid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .frame_done    (frame_done),
        .err_tlast     (err_tlast)
    );

    function automatic logic [39:0] energy_of(input logic [31:0] d);
        longint re, im;
        re = longint'($signed(d[31:16]));
        im = longint'($signed(d[15:0]));
        return 40'(re * re + im * im);
    endfunction

    // Energy computer model: fixed three-cycle latency, not reset with the DUT.
    logic [2:0]  pv = '0;
    logic [39:0] pd [3];
    always @(posedge clk) begin
        pv[0] <= eng_tvalid && eng_tready;
        pd[0] <= energy_of(eng_tdata);
        pv[1] <= pv[0];
        pd[1] <= pd[0];
        pv[2] <= pv[1];
        pd[2] <= pd[1];
    end
    assign eng_valid  = pv[2];
    assign eng_energy = pd[2];

    always @(negedge clk) eng_tready = tog ? ~eng_tready : 1'b1;

    always @(negedge clk) begin
        if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
        if (err_tlast === 1'b1) err_cnt <= err_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_beat(input string tag, input logic [31:0] data, input logic last);
        logic got;
        int   n;
        s_axis_tdata  = data;
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = last;
        got = 1'b0;
        n   = 0;
        do begin
            #1;
            got = s_axis_tready;
            if (chk_rdy) check({tag, "_rdy_follow"}, 64'(s_axis_tready), 64'(eng_tready));
            @(negedge clk);
            n++;
        end while (!got && n < 100);
        check({tag, "_accept"}, 64'(got), 64'd1);
    endtask

    // kind 0: re=k+1, im=0; kind 1: re=im=0x8000. early_tlast puts tlast on bin 7 only.
    task automatic send_frame(input string tag, input int kind, input logic early_tlast);
        logic [31:0] d;
        logic        l;
        for (int k = 0; k < 16; k++) begin
            d = (kind == 0) ? {16'(k + 1), 16'h0000} : 32'h8000_8000;
            l = early_tlast ? (k == 7) : (k == 15);
            send_beat($sformatf("%s_b%0d", tag, k), d, l);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic start_frame(input logic keep_en);
        enable = 1'b1;
        @(negedge clk);
        enable = keep_en;
    endtask

    task automatic collect(input string tag, input logic [41:0] e0, input logic [41:0] e1,
                           input logic [41:0] e2, input logic [41:0] e3, input int stall);
        logic [41:0] exp_t [4];
        int n;
        exp_t[0] = e0; exp_t[1] = e1; exp_t[2] = e2; exp_t[3] = e3;
        m_axis_tready = 1'b0;
        n = 0;
        while (m_axis_tvalid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_emit_wait"}, 64'(n < 200), 64'd1);
        for (int b = 0; b < 4; b++) begin
            if (b == 0) begin
                for (int s = 0; s < stall; s++) begin
                    check($sformatf("%s_stall%0d_tdata", tag, s), 64'(m_axis_tdata), 64'(exp_t[0]));
                    check($sformatf("%s_stall%0d_tuser", tag, s), 64'(m_axis_tuser), 64'd0);
                    check($sformatf("%s_stall%0d_tvalid", tag, s), 64'(m_axis_tvalid), 64'd1);
                    @(negedge clk);
                end
            end
            m_axis_tready = 1'b1;
            #1;
            check($sformatf("%s_band%0d_tvalid", tag, b), 64'(m_axis_tvalid), 64'd1);
            check($sformatf("%s_band%0d_tdata", tag, b), 64'(m_axis_tdata), 64'(exp_t[b]));
            check($sformatf("%s_band%0d_tuser", tag, b), 64'(m_axis_tuser), 64'(b));
            check($sformatf("%s_band%0d_tlast", tag, b), 64'(m_axis_tlast), 64'(b == 3));
            @(negedge clk);
        end
        m_axis_tready = 1'b0;
        check({tag, "_frame_done"}, 64'(frame_done), 64'd1);
        check({tag, "_tvalid_after"}, 64'(m_axis_tvalid), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_m_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, "_m_tdata"}, 64'(m_axis_tdata), 64'd0);
        check({tag, "_m_tuser"}, 64'(m_axis_tuser), 64'd0);
        check({tag, "_m_tlast"}, 64'(m_axis_tlast), 64'd0);
        check({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        check({tag, "_eng_tvalid"}, 64'(eng_tvalid), 64'd0);
        check({tag, "_eng_tdata"}, 64'(eng_tdata), 64'd0);
        check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
        check({tag, "_err_tlast"}, 64'(err_tlast), 64'd0);
    endtask

    initial begin
        int fd0, er0;
        resetn        = 1'b0;
        enable        = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'h1234_5678;
        #1;
        check_all_zero("reset");
        s_axis_tvalid = 1'b0;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_tready", 64'(s_axis_tready), 64'd0);

        // Basic frame
        fd0 = fd_cnt; er0 = err_cnt;
        start_frame(1'b0);
        send_frame("basic", 0, 1'b0);
        collect("basic", 42'd30, 42'd174, 42'd446, 42'd846, 0);
        @(negedge clk);
        check("basic_fd_pulses", 64'(fd_cnt - fd0), 64'd1);
        check("basic_err_pulses", 64'(err_cnt - er0), 64'd0);

        // Extreme negative inputs
        start_frame(1'b0);
        send_frame("extreme", 1, 1'b0);
        collect("extreme", 42'h2_0000_0000, 42'h2_0000_0000, 42'h2_0000_0000, 42'h2_0000_0000, 0);
        @(negedge clk);

        // Backpressure on both sides
        tog = 1'b1;
        chk_rdy = 1'b1;
        start_frame(1'b0);
        send_frame("bp", 0, 1'b0);
        chk_rdy = 1'b0;
        #1;
        check("bp_drain_rdy0", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        #1;
        check("bp_drain_rdy1", 64'(s_axis_tready), 64'd0);
        tog = 1'b0;
        collect("bp", 42'd30, 42'd174, 42'd446, 42'd846, 5);
        @(negedge clk);

        // tlast placement errors
        er0 = err_cnt;
        start_frame(1'b0);
        send_frame("tlast", 0, 1'b1);
        collect("tlast", 42'd30, 42'd174, 42'd446, 42'd846, 0);
        @(negedge clk);
        check("tlast_err_pulses", 64'(err_cnt - er0), 64'd2);

        // Reset one cycle after the last bin, stale results must be dropped
        start_frame(1'b0);
        send_frame("rst", 0, 1'b0);
        resetn = 1'b0;
        @(negedge clk);
        #1;
        check_all_zero("rst_mid");
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        start_frame(1'b0);
        send_frame("post_rst", 0, 1'b0);
        collect("post_rst", 42'd30, 42'd174, 42'd446, 42'd846, 0);
        @(negedge clk);

        // Back-to-back frames with enable held high
        fd0 = fd_cnt; er0 = err_cnt;
        start_frame(1'b1);
        send_frame("b2b0", 0, 1'b0);
        collect("b2b0", 42'd30, 42'd174, 42'd446, 42'd846, 0);
        #1;
        check("b2b_idle_rdy", 64'(s_axis_tready), 64'd0);
        @(negedge clk);
        #1;
        check("b2b_feed_rdy", 64'(s_axis_tready), 64'd1);
        send_frame("b2b1", 0, 1'b0);
        enable = 1'b0;
        collect("b2b1", 42'd30, 42'd174, 42'd446, 42'd846, 0);
        @(negedge clk);
        check("b2b_fd_pulses", 64'(fd_cnt - fd0), 64'd2);
        check("b2b_err_pulses", 64'(err_cnt - er0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/k_energy_frame_ctrl.md
Name: k_energy_frame_ctrl

Overview:
Frame-level controller for k_energy_computer. It gates one FFT frame of complex bins (AXI-stream, FFT_NUM_PTS beats) into the energy computer and counts the returned per-bin energies. It accumulates those energies into NUM_BANDS equal-width bands and then streams the band totals to the compressor gain stage. Sits between the FFT output stream and the compressor's band-gain logic.

Parameters:
IN_WIDTH, 16, width of each re/im component
OUT_WIDTH, 40, width of energy computer result
FFT_NUM_PTS, 16, bins per frame (power of 2)
NUM_BANDS, 4, bands per frame (power of 2, divides FFT_NUM_PTS)
ACC_WIDTH, OUT_WIDTH+log2(FFT_NUM_PTS/NUM_BANDS), band accumulator width

Ports:
clk  in  1  single clock, all logic on rising edge
resetn  in  1  synchronous, active-low reset
enable  in  1  permits a new frame to start from IDLE
s_axis_tdata  in  2*IN_WIDTH  {re,im} bin from FFT
s_axis_tvalid  in  1  bin valid
s_axis_tlast  in  1  FFT frame marker
s_axis_tready  out  1  bin accepted
eng_tdata  out  2*IN_WIDTH  to energy computer s_axis_tdata
eng_tvalid  out  1  to energy computer s_axis_tvalid
eng_tready  in  1  from energy computer s_axis_tready
eng_energy  in  OUT_WIDTH  energy computer out_energy
eng_valid  in  1  energy computer out_valid
m_axis_tdata  out  ACC_WIDTH  band energy total
m_axis_tuser  out  log2(NUM_BANDS)  band index
m_axis_tlast  out  1  high on last band
m_axis_tvalid  out  1  band result valid
m_axis_tready  in  1  downstream ready
frame_done  out  1  one-cycle pulse after last band handshake
err_tlast  out  1  one-cycle pulse on tlast mismatch

Behaviour:
- Reset (resetn=0 at clk edge): state=IDLE; all counters and accumulators 0; every output 0. Applies mid-frame; in-flight energy-computer results after reset are ignored until the next FEED.
- States: IDLE, FEED, DRAIN, EMIT.
- IDLE: accumulators, bin_cnt, res_cnt cleared; s_axis_tready=0. enable=1 -> FEED next cycle.
- FEED: eng_tdata=s_axis_tdata, eng_tvalid=s_axis_tvalid, s_axis_tready=eng_tready (combinational pass-through, zero added latency). Beat accepted when s_axis_tvalid&&eng_tready; bin_cnt++. Accepting bin FFT_NUM_PTS-1 -> DRAIN.
- tlast check per accepted beat: tlast=1 at bin_cnt!=FFT_NUM_PTS-1, or tlast=0 at the last bin -> err_tlast pulses the next cycle. The frame length is still fixed by bin_cnt; there is no resync.
- Result capture (FEED and DRAIN only): each eng_valid adds eng_energy (zero-extended) to acc[res_cnt / (FFT_NUM_PTS/NUM_BANDS)]; res_cnt++. eng_valid in IDLE or EMIT is ignored.
- DRAIN: s_axis_tready=0, eng_tvalid=0. The cycle res_cnt reaches FFT_NUM_PTS -> EMIT, with band_idx=0.
- A result may arrive in the same cycle the last bin is fed; it is counted normally.
- EMIT: m_axis_tvalid=1, m_axis_tdata=acc[band_idx], m_axis_tuser=band_idx, m_axis_tlast=(band_idx==NUM_BANDS-1). Outputs are registered and held stable while tready=0. On handshake band_idx++. Last-band handshake -> IDLE, and frame_done pulses in the same cycle as entering IDLE.
- Back-to-back frames: with enable held high, IDLE lasts exactly one cycle between frames.
- Arithmetic: unsigned, no saturation needed; ACC_WIDTH holds the worst-case band sum.

Decomposition:
- Package k_aud_cmprs_pkg holds: state enum (IDLE/FEED/DRAIN/EMIT), the BINS_PER_BAND localparam, and the clog2-derived widths for bin_cnt, res_cnt and band_idx.
- Natural sub-module: k_band_accumulator. It holds the NUM_BANDS register bank with add-on-valid, clear and read-by-index ports. The FSM stays in the top module.

Test Plan:
- The bench models the energy computer as re²+im² (signed inputs), fixed latency 3, eng_tready=1. Configuration: FFT_NUM_PTS=16, NUM_BANDS=4.
- Basic frame: bins re=k+1, im=0 (k=0..15), tlast on bin 15 -> m_axis outputs 30, 174, 446, 846 with tuser 0..3; tlast on band 3; frame_done pulses once; err_tlast never pulses.
- Negative/extreme: all bins re=im=16'h8000 -> each energy 2^31, each band total 2^33; no wrap within ACC_WIDTH=42.
- Backpressure: toggle eng_tready 1/0 each cycle and hold m_axis_tready=0 for 5 cycles in EMIT -> same totals as the basic frame; m_axis_tdata/tuser stable while stalled; s_axis_tready follows eng_tready only in FEED.
- tlast errors: tlast on bin 7, then none on bin 15 -> err_tlast pulses twice; frame still completes after 16 bins with the correct sums.
- Reset mid-DRAIN: assert resetn=0 one cycle after bin 15 -> all outputs 0 next cycle. Two stale eng_valid pulses are ignored; the next frame yields the basic-frame totals exactly.
- Back-to-back: enable held high, two basic frames -> 8 band beats, two frame_done pulses, one IDLE cycle between the frames.
